fetch: RTL and testbench

Instruction fetch stage of the kleine-riscv pipeline, directly upstream of `decode`. Holds the fetch PC, issues one instruction-memory request at a time, and presents `instr`/`pc_out`/`next_pc_out`/`valid_out` to decode. It absorbs decode back-pressure with a one-entry skid buffer. A redirect from execute kills in-flight and buffered fetches and restarts at the target.

---
 rtl/fetch.sv | 163 ++++++++++++++++
 tb/tb_fetch.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch.sv
// Instruction fetch stage: owns the fetch PC, keeps at most one
// instruction-memory request in flight, and hands instructions to decode
// through an output register backed by a one-entry skid buffer.
module fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h80000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    output logic [31:0] next_pc_out,
    output logic        valid_out
);

    typedef enum logic [1:0] {
        S_REQ     = 2'd0,  // ready to issue a request
        S_WAIT    = 2'd1,  // live request outstanding
        S_DISCARD = 2'd2   // stale request outstanding, response will be dropped
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_pc_q, req_pc_d;

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] next_pc_q, next_pc_d;
    logic        valid_q, valid_d;

    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic        buf_valid_q, buf_valid_d;

    logic handshake;
    logic resp_valid;
    logic out_free;

    // Requests only go out when the skid buffer is empty, so every response has a slot.
    assign mem_req    = (state_q == S_REQ) && !buf_valid_q && !reset;
    assign mem_addr   = fetch_pc_q;
    assign handshake  = mem_req && mem_ready;
    assign resp_valid = (state_q == S_WAIT) && mem_rvalid && !branch_taken;
    assign out_free   = !valid_q || !stall;

    assign instr       = instr_q;
    assign pc_out      = pc_q;
    assign next_pc_out = next_pc_q;
    assign valid_out   = valid_q;

    // Request FSM: next state, fetch PC and outstanding-request PC.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        case (state_q)
            S_REQ: begin
                if (handshake) begin
                    if (branch_taken) begin
                        fetch_pc_d = branch_target;
                        state_d    = S_DISCARD;
                    end else begin
                        req_pc_d   = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        state_d    = S_WAIT;
                    end
                end else if (branch_taken) begin
                    fetch_pc_d = branch_target;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    if (branch_taken) fetch_pc_d = branch_target;
                    state_d = S_REQ;
                end else if (branch_taken) begin
                    fetch_pc_d = branch_target;
                    state_d    = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (branch_taken) fetch_pc_d = branch_target;
                if (mem_rvalid)   state_d    = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
    end

    // Delivery into the output register and skid buffer; a redirect flushes both.
    always_comb begin
        instr_d     = instr_q;
        pc_d        = pc_q;
        next_pc_d   = next_pc_q;
        valid_d     = valid_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        buf_valid_d = buf_valid_q;
        if (branch_taken) begin
            valid_d     = 1'b0;
            buf_valid_d = 1'b0;
        end else if (out_free) begin
            if (buf_valid_q) begin
                instr_d   = buf_instr_q;
                pc_d      = buf_pc_q;
                next_pc_d = buf_pc_q + 32'd4;
                valid_d   = 1'b1;
                if (resp_valid) begin
                    buf_instr_d = mem_rdata;
                    buf_pc_d    = req_pc_q;
                end else begin
                    buf_valid_d = 1'b0;
                end
            end else if (resp_valid) begin
                instr_d   = mem_rdata;
                pc_d      = req_pc_q;
                next_pc_d = req_pc_q + 32'd4;
                valid_d   = 1'b1;
            end else begin
                valid_d = 1'b0;
            end
        end else if (resp_valid) begin
            buf_instr_d = mem_rdata;
            buf_pc_d    = req_pc_q;
            buf_valid_d = 1'b1;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_REQ;
            fetch_pc_q  <= RESET_VECTOR;
            req_pc_q    <= '0;
            instr_q     <= '0;
            pc_q        <= '0;
            next_pc_q   <= '0;
            valid_q     <= 1'b0;
            buf_instr_q <= '0;
            buf_pc_q    <= '0;
            buf_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            req_pc_q    <= req_pc_d;
            instr_q     <= instr_d;
            pc_q        <= pc_d;
            next_pc_q   <= next_pc_d;
            valid_q     <= valid_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
            buf_valid_q <= buf_valid_d;
        end
    end

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: a memory model with programmable latency,
// and a scoreboard of instructions that decode must see, in order.
module tb_fetch;

    localparam logic [31:0] RV = 32'h80000000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic [31:0] next_pc_out;
    logic        valid_out;

    fetch #(.RESET_VECTOR(RV)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ready    (mem_ready),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .instr        (instr),
        .pc_out       (pc_out),
        .next_pc_out  (next_pc_out),
        .valid_out    (valid_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } item_t;

    item_t       sb[$];       // [0] = output register, [1] = skid buffer
    int          n_pass = 0;
    int          n_fail = 0;
    int          n_total = 0;
    logic [31:0] exp_addr;    // where the next request must go
    bit          busy;        // a request is outstanding in memory
    bit          drop;        // the outstanding response must be discarded
    int          cnt;
    int          lat = 1;
    logic [31:0] pend;

    // Memory contents: address-derived, so RESET_VECTOR holds 32'h00000013.
    function automatic logic [31:0] dat(input logic [31:0] a);
        return a ^ 32'h80000013;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare every visible output against the model.
    task automatic observe();
        bit exp_req;
        exp_req = !reset && !busy && (sb.size() < 2);
        check("mem_req", {31'b0, mem_req}, {31'b0, exp_req});
        if (exp_req) check("mem_addr", mem_addr, exp_addr);
        check("valid_out", {31'b0, valid_out}, {31'b0, sb.size() != 0});
        if (sb.size() != 0) begin
            check("pc_out", pc_out, sb[0].pc);
            check("instr", instr, sb[0].ins);
            check("next_pc_out", next_pc_out, sb[0].pc + 32'd4);
        end
    endtask

    // One clock cycle: update model from this cycle's inputs, clock, re-check.
    task automatic tick();
        bit    hs;
        bit    rv;
        item_t it;
        hs = mem_req && mem_ready;
        rv = busy && (cnt == 0);
        if (!stall && sb.size() != 0) it = sb.pop_front();
        if (branch_taken) sb.delete();
        else if (rv && !drop) begin
            it.pc  = pend;
            it.ins = dat(pend);
            sb.push_back(it);
        end
        if (rv) busy = 0;
        else if (busy) begin
            cnt--;
            if (branch_taken) drop = 1;
        end
        if (hs) begin
            busy     = 1;
            cnt      = lat - 1;
            pend     = mem_addr;
            drop     = branch_taken;
            exp_addr = exp_addr + 32'd4;
        end
        if (branch_taken) exp_addr = branch_target;
        @(posedge clk);
        #1;
        mem_rvalid = busy && (cnt == 0);
        mem_rdata  = (busy && cnt == 0) ? dat(pend) : $urandom;
        observe();
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        mem_rvalid = 1'b0;
        #1;
        busy     = 0;
        drop     = 0;
        sb.delete();
        exp_addr = RV;
        observe();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        observe();
    endtask

    initial begin
        reset         = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        mem_ready     = 1'b1;
        mem_rvalid    = 1'b0;
        mem_rdata     = '0;
        busy          = 0;
        drop          = 0;
        cnt           = 0;
        pend          = '0;
        exp_addr      = RV;
        #2;
        do_reset();
        check("rst_instr", instr, 32'h0);
        check("rst_pc", pc_out, 32'h0);
        check("rst_next_pc", next_pc_out, 32'h0);
        check("first_addr", mem_addr, 32'h80000000);

        // First fetch at k=1.
        tick();
        tick();
        check("first_valid", {31'b0, valid_out}, 32'h1);
        check("first_pc", pc_out, 32'h80000000);
        check("first_next_pc", next_pc_out, 32'h80000004);
        check("first_instr", instr, 32'h00000013);
        check("second_addr", mem_addr, 32'h80000004);

        // Stall: second response lands in the skid buffer, requests stop.
        stall = 1'b1;
        tick();
        tick();
        repeat (3) begin
            tick();
            check("stall_no_req", {31'b0, mem_req}, 32'h0);
            check("stall_hold_pc", pc_out, 32'h80000000);
        end
        stall = 1'b0;
        tick();
        check("unstall_buf_pc", pc_out, 32'h80000004);

        // Redirect during WAIT, response comes back later and is dropped.
        lat = 3;
        tick();
        branch_taken  = 1'b1;
        branch_target = 32'h00000100;
        tick();
        branch_taken = 1'b0;
        tick();
        tick();
        check("redir_valid", {31'b0, valid_out}, 32'h0);
        check("redir_addr", mem_addr, 32'h00000100);

        // Redirect together with a response while the output is stalled.
        lat = 1;
        tick();
        tick();
        stall = 1'b1;
        tick();
        branch_taken  = 1'b1;
        branch_target = 32'h00000200;
        tick();
        branch_taken = 1'b0;
        check("br_rv_valid", {31'b0, valid_out}, 32'h0);
        check("br_rv_addr", mem_addr, 32'h00000200);

        // Redirect with output and skid buffer both full.
        tick();
        tick();
        tick();
        tick();
        check("buf_full_no_req", {31'b0, mem_req}, 32'h0);
        branch_taken  = 1'b1;
        branch_target = 32'h00000300;
        tick();
        branch_taken = 1'b0;
        stall        = 1'b0;
        check("br_full_valid", {31'b0, valid_out}, 32'h0);
        check("br_full_req", {31'b0, mem_req}, 32'h1);
        check("br_full_addr", mem_addr, 32'h00000300);

        // Wrap-around at the top of the address space.
        mem_ready     = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'hFFFFFFFC;
        tick();
        branch_taken = 1'b0;
        mem_ready    = 1'b1;
        tick();
        tick();
        check("wrap_pc", pc_out, 32'hFFFFFFFC);
        check("wrap_next_pc", next_pc_out, 32'h00000000);
        check("wrap_addr", mem_addr, 32'h00000000);

        // Memory not ready: request held steady.
        mem_ready = 1'b0;
        repeat (5) begin
            tick();
            check("hold_req", {31'b0, mem_req}, 32'h1);
            check("hold_addr", mem_addr, 32'h00000000);
        end
        mem_ready = 1'b1;

        // Mixed traffic: random stall, ready, latency and redirects.
        repeat (300) begin
            stall         = ($urandom_range(0, 2) == 0);
            mem_ready     = ($urandom_range(0, 3) != 0);
            lat           = $urandom_range(1, 3);
            branch_taken  = ($urandom_range(0, 15) == 0);
            branch_target = $urandom & 32'hFFFFFFFC;
            tick();
        end
        stall        = 1'b0;
        branch_taken = 1'b0;
        mem_ready    = 1'b1;

        // Reset while a request is outstanding; a late response is ignored.
        lat = 3;
        repeat (10) if (!busy) tick();
        check("reach_wait", {31'b0, busy}, 32'h1);
        do_reset();
        mem_ready  = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEADBEEF;
        tick();
        check("late_rv_valid", {31'b0, valid_out}, 32'h0);
        check("late_rv_addr", mem_addr, RV);
        mem_ready = 1'b1;
        lat       = 1;
        tick();
        tick();
        check("post_rst_pc", pc_out, RV);
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
